// File: rtl/axi_dw_allocator.sv
// rtl/axi_dw_allocator.sv - W-channel router for one master port, steered by the AW grant-order ID FIFO
module axi_dw_allocator #(
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_USER_W  = 6,
    parameter int N_TARG_PORT = 7,
    parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [N_TARG_PORT*AXI_DATA_W-1:0]       wdata_i,
    input  logic [N_TARG_PORT*(AXI_DATA_W/8)-1:0]   wstrb_i,
    input  logic [N_TARG_PORT-1:0]                  wlast_i,
    input  logic [N_TARG_PORT*AXI_USER_W-1:0]       wuser_i,
    input  logic [N_TARG_PORT-1:0]                  wvalid_i,
    output logic [N_TARG_PORT-1:0]                  wready_o,
    output logic [AXI_DATA_W-1:0]                   wdata_o,
    output logic [AXI_DATA_W/8-1:0]                 wstrb_o,
    output logic                                    wlast_o,
    output logic [AXI_USER_W-1:0]                   wuser_o,
    output logic                                    wvalid_o,
    input  logic                                    wready_i,
    input  logic                                    push_ID_i,
    input  logic [LOG_N_TARG+N_TARG_PORT-1:0]       ID_i,
    output logic                                    grant_FIFO_ID_o
);
    localparam int ID_W   = LOG_N_TARG + N_TARG_PORT;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int STRB_W = AXI_DATA_W / 8;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [ID_W-1:0]        fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wptr_q, wptr_d;
    logic [PTR_W-1:0]       rptr_q, rptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ID_W-1:0]        head;
    logic [N_TARG_PORT-1:0] onehot;
    logic [LOG_N_TARG-1:0]  sel;
    logic                   empty;
    logic                   push;
    logic                   pop;

    assign empty           = (count_q == '0);
    assign grant_FIFO_ID_o = (count_q != CNT_FULL);
    assign push            = push_ID_i && grant_FIFO_ID_o;
    assign pop             = wvalid_o && wready_i && wlast_o;

    assign head   = fifo_q[rptr_q];
    assign onehot = head[N_TARG_PORT-1:0];
    assign sel    = head[ID_W-1:N_TARG_PORT];

    // Forwarding is purely combinational; an empty FIFO blanks the whole master-side W.
    always_comb begin
        wvalid_o = 1'b0;
        wready_o = '0;
        wdata_o  = '0;
        wstrb_o  = '0;
        wlast_o  = 1'b0;
        wuser_o  = '0;
        if (!empty) begin
            wvalid_o = |(wvalid_i & onehot);
            wready_o = onehot & {N_TARG_PORT{wready_i}};
            for (int p = 0; p < N_TARG_PORT; p++) begin
                if (sel == LOG_N_TARG'(p)) begin
                    wdata_o = wdata_i[p*AXI_DATA_W +: AXI_DATA_W];
                    wstrb_o = wstrb_i[p*STRB_W +: STRB_W];
                    wlast_o = wlast_i[p];
                    wuser_o = wuser_i[p*AXI_USER_W +: AXI_USER_W];
                end
            end
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entries are qualified by count_q, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= ID_i;
        end
    end
endmodule

// File: tb/tb_axi_dw_allocator.sv
// tb/tb_axi_dw_allocator.sv - self-checking bench for axi_dw_allocator (4 ports, depth 4)
module tb_axi_dw_allocator;
    localparam int DW = 64;
    localparam int UW = 6;
    localparam int NP = 4;
    localparam int LN = 2;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP*DW-1:0]  wdata_i;
    logic [NP*8-1:0]   wstrb_i;
    logic [NP-1:0]     wlast_i;
    logic [NP*UW-1:0]  wuser_i;
    logic [NP-1:0]     wvalid_i;
    logic [NP-1:0]     wready_o;
    logic [DW-1:0]     wdata_o;
    logic [7:0]        wstrb_o;
    logic              wlast_o;
    logic [UW-1:0]     wuser_o;
    logic              wvalid_o;
    logic              wready_i;
    logic              push_ID_i;
    logic [LN+NP-1:0]  ID_i;
    logic              grant_FIFO_ID_o;

    int n_total = 0;
    int n_pass  = 0;

    axi_dw_allocator #(
        .AXI_DATA_W(DW), .AXI_USER_W(UW), .N_TARG_PORT(NP), .LOG_N_TARG(LN), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wuser_i(wuser_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wuser_o(wuser_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i),
        .push_ID_i(push_ID_i), .ID_i(ID_i), .grant_FIFO_ID_o(grant_FIFO_ID_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       push;
        int         id_port;
        logic [3:0] wv;
        logic [3:0] wl;
        logic       wr;
        logic       e_grant;
        logic       e_wv;
        logic [3:0] e_wr;
        int         e_port;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [LN+NP-1:0] id_of(input int p);
        logic [NP-1:0] oh;
        oh = 4'b0001 << p;
        return {LN'(p), oh};
    endfunction

    task automatic check_outs(input string tag, input logic e_grant, input logic e_wv,
                              input logic [3:0] e_wr, input int e_port);
        logic [DW-1:0] ed;
        logic [7:0]    es;
        logic          el;
        logic [UW-1:0] eu;
        ed = '0; es = '0; el = 1'b0; eu = '0;
        if (e_port >= 0) begin
            ed = wdata_i[e_port*DW +: DW];
            es = wstrb_i[e_port*8 +: 8];
            el = wlast_i[e_port];
            eu = wuser_i[e_port*UW +: UW];
        end
        check({tag, ".grant"},  64'(grant_FIFO_ID_o), 64'(e_grant));
        check({tag, ".wvalid"}, 64'(wvalid_o), 64'(e_wv));
        check({tag, ".wready"}, 64'(wready_o), 64'(e_wr));
        check({tag, ".wdata"},  wdata_o, ed);
        check({tag, ".wstrb"},  64'(wstrb_o), 64'(es));
        check({tag, ".wlast"},  64'(wlast_o), 64'(el));
        check({tag, ".wuser"},  64'(wuser_o), 64'(eu));
    endtask

    task automatic fixed_payload();
        for (int p = 0; p < NP; p++) begin
            wdata_i[p*DW +: DW] = 64'hDA7A_0000_0000_0000 | (64'(p) << 8) | 64'(p + 1);
            wstrb_i[p*8 +: 8]   = 8'h80 | 8'(1 << p);
            wuser_i[p*UW +: UW] = UW'(p + 5);
        end
    endtask

    task automatic drive(input logic push, input int port, input logic [3:0] wv,
                         input logic [3:0] wl, input logic wr);
        push_ID_i = push;
        ID_i      = id_of(port);
        wvalid_i  = wv;
        wlast_i   = wl;
        wready_i  = wr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 4'h0, 4'h0, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic step_check(input string tag, input logic push, input int port,
                              input logic [3:0] wv, input logic [3:0] wl, input logic wr,
                              input logic e_grant, input logic e_wv, input logic [3:0] e_wr,
                              input int e_port);
        drive(push, port, wv, wl, wr);
        @(negedge clk);
        check_outs(tag, e_grant, e_wv, e_wr, e_port);
        tick();
    endtask

    int q [$];

    initial begin
        fixed_payload();
        // reset/idle, single 4-beat burst from port 2, then order 3,0,3 with len 2
        tbl[0]  = '{1'b0, 0, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, -1};
        tbl[1]  = '{1'b1, 2, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, -1};
        tbl[2]  = '{1'b0, 0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0100, 2};
        tbl[3]  = '{1'b0, 0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0100, 2};
        tbl[4]  = '{1'b0, 0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0100, 2};
        tbl[5]  = '{1'b0, 0, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100, 2};
        tbl[6]  = '{1'b0, 0, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000, -1};
        tbl[7]  = '{1'b1, 3, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, -1};
        tbl[8]  = '{1'b1, 0, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b1000, 3};
        tbl[9]  = '{1'b1, 3, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b1000, 3};
        tbl[10] = '{1'b0, 0, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0001, 0};
        tbl[11] = '{1'b0, 0, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0001, 0};
        tbl[12] = '{1'b0, 0, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b1000, 3};
        tbl[13] = '{1'b0, 0, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b1000, 3};
        tbl[14] = '{1'b0, 0, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000, -1};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            step_check($sformatf("tbl%0d", i), tbl[i].push, tbl[i].id_port, tbl[i].wv,
                       tbl[i].wl, tbl[i].wr, tbl[i].e_grant, tbl[i].e_wv, tbl[i].e_wr,
                       tbl[i].e_port);
        end

        // backpressure mid-burst on port 1
        do_reset();
        step_check("bp.push", 1, 1, 4'b0000, 4'b0000, 1'b1, 1, 0, 4'b0000, -1);
        step_check("bp.b1", 0, 0, 4'b0010, 4'b0000, 1'b1, 1, 1, 4'b0010, 1);
        for (int i = 0; i < 5; i++)
            step_check("bp.stall", 0, 0, 4'b0010, 4'b0010, 1'b0, 1, 1, 4'b0000, 1);
        step_check("bp.last", 0, 0, 4'b0010, 4'b0010, 1'b1, 1, 1, 4'b0010, 1);
        step_check("bp.empty", 0, 0, 4'b1111, 4'b0000, 1'b1, 1, 0, 4'b0000, -1);

        // full FIFO: 5th push and push-during-pop are both dropped
        do_reset();
        for (int i = 0; i < 4; i++)
            step_check("full.fill", 1, i, 4'b0000, 4'b0000, 1'b0, 1, 0, 4'b0000, (i == 0) ? -1 : 0);
        step_check("full.5th", 1, 0, 4'b0000, 4'b0000, 1'b0, 0, 0, 4'b0000, 0);
        step_check("full.pop", 1, 0, 4'b1111, 4'b1111, 1'b1, 0, 1, 4'b0001, 0);
        step_check("full.p1", 0, 0, 4'b1111, 4'b1111, 1'b1, 1, 1, 4'b0010, 1);
        step_check("full.p2", 0, 0, 4'b1111, 4'b1111, 1'b1, 1, 1, 4'b0100, 2);
        step_check("full.p3", 0, 0, 4'b1111, 4'b1111, 1'b1, 1, 1, 4'b1000, 3);
        step_check("full.empty", 0, 0, 4'b1111, 4'b1111, 1'b1, 1, 0, 4'b0000, -1);

        // simultaneous push and pop at count 2
        do_reset();
        step_check("pp.push1", 1, 1, 4'b0000, 4'b0000, 1'b0, 1, 0, 4'b0000, -1);
        step_check("pp.push2", 1, 2, 4'b0000, 4'b0000, 1'b0, 1, 0, 4'b0000, 1);
        step_check("pp.both", 1, 3, 4'b1111, 4'b1111, 1'b1, 1, 1, 4'b0010, 1);
        step_check("pp.h2a", 0, 0, 4'b1111, 4'b0000, 1'b1, 1, 1, 4'b0100, 2);
        step_check("pp.h2b", 0, 0, 4'b1111, 4'b1111, 1'b1, 1, 1, 4'b0100, 2);
        step_check("pp.h3", 0, 0, 4'b1111, 4'b1111, 1'b1, 1, 1, 4'b1000, 3);
        step_check("pp.empty", 0, 0, 4'b1111, 4'b1111, 1'b1, 1, 0, 4'b0000, -1);

        // asynchronous reset in the middle of a burst
        do_reset();
        step_check("ar.push", 1, 1, 4'b0000, 4'b0000, 1'b0, 1, 0, 4'b0000, -1);
        step_check("ar.b1", 0, 0, 4'b0010, 4'b0000, 1'b1, 1, 1, 4'b0010, 1);
        #2 rst_n = 1'b0;
        #1 check_outs("ar.async", 1, 0, 4'b0000, -1);
        tick();
        rst_n = 1'b1;
        step_check("ar.after", 0, 0, 4'b0010, 4'b0010, 1'b1, 1, 0, 4'b0000, -1);

        // randomized traffic against a queue model of the ID order
        do_reset();
        q.delete();
        for (int c = 0; c < 2000; c++) begin
            int       hp;
            logic     e_wv;
            logic [3:0] e_wr;
            logic     do_pop;
            logic     do_push;
            int       rport;
            for (int p = 0; p < NP; p++) begin
                wdata_i[p*DW +: DW] = {$urandom, $urandom};
                wstrb_i[p*8 +: 8]   = 8'($urandom);
                wuser_i[p*UW +: UW] = UW'($urandom);
            end
            rport = $urandom_range(0, NP - 1);
            drive(($urandom_range(0, 1) == 1), rport, 4'($urandom),
                  4'($urandom) & 4'($urandom), ($urandom_range(0, 9) < 7));
            @(negedge clk);
            hp   = (q.size() == 0) ? -1 : q[0];
            e_wv = (hp >= 0) ? wvalid_i[hp] : 1'b0;
            e_wr = (hp >= 0 && wready_i) ? (4'b0001 << hp) : 4'b0000;
            check_outs("rnd", (q.size() != DEPTH), e_wv, e_wr, hp);
            do_pop  = (hp >= 0) && wvalid_i[hp] && wready_i && wlast_i[hp];
            do_push = push_ID_i && (q.size() < DEPTH);
            @(posedge clk);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(rport);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/axi_dw_allocator.md
# axi_DW_allocator

Write-data allocator for one master port of the AXI node: it receives the ordered stream of granted write-address IDs from the AW allocator and routes W beats from the matching slave port to the master port. Routing follows strict AW grant order, one burst per ID entry. It sits directly downstream of the AW allocator's ID push interface and in parallel with its AW output, on the W channel of the same master port.

## Interface
- AXI_DATA_W, 64: W data width in bits; AXI_DATA_W/8 strobe bits.
- AXI_USER_W, 6: W user width.
- N_TARG_PORT, 7: number of slave (target) ports.
- LOG_N_TARG, $clog2(N_TARG_PORT): binary port-index width.
- FIFO_DEPTH, 8: ID FIFO entries; any value ≥ 2, not required to be a power of two.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wdata_i  in  N_TARG_PORT×AXI_DATA_W  per-port write data.
- wstrb_i  in  N_TARG_PORT×(AXI_DATA_W/8)  per-port byte strobes.
- wlast_i  in  N_TARG_PORT  per-port last beat.
- wuser_i  in  N_TARG_PORT×AXI_USER_W  per-port user.
- wvalid_i  in  N_TARG_PORT  per-port valid.
- wready_o  out  N_TARG_PORT  per-port ready.
- wdata_o / wstrb_o / wlast_o / wuser_o  out  AXI_DATA_W / AXI_DATA_W/8 / 1 / AXI_USER_W  master-port W payload.
- wvalid_o  out  1  master-port valid.
- wready_i  in  1  master-port ready.
- push_ID_i  in  1  push strobe from the AW allocator.
- ID_i  in  LOG_N_TARG+N_TARG_PORT  {binary port index, one-hot port index}.
- grant_FIFO_ID_o  out  1  FIFO can accept a push.

## Operation
- ID FIFO: FIFO_DEPTH × (LOG_N_TARG+N_TARG_PORT). Read/write pointers wrap from FIFO_DEPTH-1 to 0. Occupancy counter is $clog2(FIFO_DEPTH+1) bits wide.
- grant_FIFO_ID_o = (count != FIFO_DEPTH). It is a registered-state function only and never depends on push_ID_i.
- Push: when push_ID_i && grant_FIFO_ID_o, write ID_i at the write pointer. push_ID_i while full is ignored; the FIFO is not corrupted.
- Head decode: onehot = head[N_TARG_PORT-1:0], sel = head[LOG_N_TARG+N_TARG_PORT-1:N_TARG_PORT].
- When not empty:
  - wvalid_o = |(wvalid_i & onehot).
  - wready_o = onehot & {N_TARG_PORT{wready_i}}.
  - Payload outputs = port sel's wdata/wstrb/wlast/wuser.
- When empty: wvalid_o=0, wready_o=0, and all payload outputs are 0.
- Beat transfer: wvalid_o && wready_i. The pop condition is transfer && wlast_o; the read pointer advances and count decrements on that edge.
- Push and pop in the same cycle: both take effect and count is unchanged.
- Full FIFO with a pop in the same cycle: no push is accepted that cycle because grant is low. The grant rises the following cycle.
- No fall-through: an ID pushed in cycle t becomes the head no earlier than t+1.
- Non-selected ports always see wready_o=0, whatever their wvalid_i.
- Undefined input (not required to handle): a one-hot field with more than one bit set, or binary and one-hot fields that disagree.

## Timing
- Reset values: count=0, pointers=0, grant_FIFO_ID_o=1, wvalid_o=0, wready_o=0, payload outputs=0.
- Reset asserted mid-burst: the FIFO empties immediately (asynchronously) and any partial burst is dropped.
- Latency: push at edge t lets the first beat transfer combinationally in cycle t+1.
- Forwarding: wvalid_o, wready_o and payload are combinational from inputs and head state. There is no pipeline register on W.
- Throughput: one beat per cycle, including back-to-back bursts from different ports. The next head is valid in the cycle after the wlast transfer.
- grant_FIFO_ID_o changes only after a clock edge or reset.

## Test plan
- Reset then idle: after rst_n release, with wvalid_i=4'b1111 (N_TARG_PORT=4), push_ID_i=0 → grant=1, wvalid_o=0, wready_o=0000, wdata_o=0.
- Single burst: push ID {2'd2, 4'b0100}. Next cycle, port 2 drives 4 beats with wlast on beat 4 and wready_i=1 → 4 transfers in 4 consecutive cycles carrying port 2 data, wready_o=0100 throughout, FIFO empty after the 4th edge.
- Order preservation: push IDs for ports 3, 0, 3 in consecutive cycles, all ports valid with len 2 → master sees port 3, then 0, then 3 with no idle cycle between bursts.
- Backpressure: wready_i=0 for 5 cycles mid-burst → wvalid_o held at 1, payload stable, wready_o=0000, no pop.
- Full: FIFO_DEPTH=4, push 4 IDs with no W traffic → grant=0. A 5th push is ignored. Completing one burst → grant=1 the cycle after the wlast transfer, and only 4 bursts are ever forwarded.
- Simultaneous push/pop at count=2: wlast transfer and push in the same cycle → count stays 2, new ID is served after the remaining entry.
